// File: rtl/rv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rv_pkg: register-file write request type and widths shared by  |
// | the writeback arbiter and its result FIFO.  Rev 1.0            |
// +----------------------------------------------------------------+
package rv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------+
// | sync_fifo: single-clock FIFO of write requests; head is shown  |
// | combinationally so a pop writes it in the same cycle. Rev 1.0  |
// +----------------------------------------------------------------+
module sync_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_req_t          push_data,
  input  logic             pop,
  output wb_req_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | wb_port_arbiter: shares the register-file write port between   |
// | pipeline writeback and buffered MDU results.  Rev 1.0          |
// +----------------------------------------------------------------+
module wb_port_arbiter
  import rv_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_wren_W,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_W,
  input  logic [XLEN-1:0]       i_result_W,
  input  logic                  i_mdu_valid,
  input  logic [REG_ADDR_W-1:0] i_mdu_rd_addr,
  input  logic [XLEN-1:0]       i_mdu_data,
  output logic                  o_mdu_ready,
  output logic                  o_rf_wren,
  output logic [REG_ADDR_W-1:0] o_rf_addr,
  output logic [XLEN-1:0]       o_rf_data,
  output logic                  o_stall_W,
  output logic [CNT_W-1:0]      o_fifo_count
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                pipe_wr;
  logic                mdu_accept;
  logic                mdu_wr;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                bypass;
  logic                pipe_win;
  wb_req_t             head;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_nxt;

  assign pipe_wr     = i_rd_wren_W && (i_rd_addr_W != '0);
  assign o_mdu_ready = !fifo_full;
  assign mdu_accept  = i_mdu_valid && o_mdu_ready;
  assign mdu_wr      = mdu_accept && (i_mdu_rd_addr != '0);

  always_comb begin
    pop       = 1'b0;
    bypass    = 1'b0;
    pipe_win  = 1'b0;
    o_rf_wren = 1'b0;
    o_rf_addr = '0;
    o_rf_data = '0;
    if (!i_rst) begin
      if (o_stall_W && !fifo_empty) begin
        // Forced drain: the frozen WB stage re-presents its write next cycle.
        pop       = 1'b1;
        o_rf_wren = 1'b1;
        o_rf_addr = head.rd;
        o_rf_data = head.data;
      end else if (pipe_wr) begin
        pipe_win  = 1'b1;
        o_rf_wren = 1'b1;
        o_rf_addr = i_rd_addr_W;
        o_rf_data = i_result_W;
      end else if (!fifo_empty) begin
        pop       = 1'b1;
        o_rf_wren = 1'b1;
        o_rf_addr = head.rd;
        o_rf_data = head.data;
      end else if (mdu_wr) begin
        bypass    = 1'b1;
        o_rf_wren = 1'b1;
        o_rf_addr = i_mdu_rd_addr;
        o_rf_data = i_mdu_data;
      end
    end
  end

  assign push = mdu_wr && !bypass && !i_rst;

  sync_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data ('{rd: i_mdu_rd_addr, data: i_mdu_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_fifo_count)
  );

  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || fifo_empty) begin
      starve_nxt = '0;
    end else if (pipe_win && (starve_cnt < STARVE_W'(STARVE_LIMIT))) begin
      starve_nxt = starve_cnt + STARVE_W'(1);
    end
  end

  // A counter reaching the limit implies no pop this cycle, so the FIFO
  // is still non-empty when the stall pulse is presented.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
      o_stall_W  <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      o_stall_W  <= !o_stall_W && !fifo_empty &&
                    (starve_nxt == STARVE_W'(STARVE_LIMIT));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_wb_port_arbiter: directed stimulus with a write scoreboard  |
// | for the writeback port arbiter.  Rev 1.0                       |
// +----------------------------------------------------------------+
module tb_wb_port_arbiter;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_wren;
  logic [4:0]  rd_addr;
  logic [31:0] result;
  logic        mdu_valid;
  logic [4:0]  mdu_rd_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_wren;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        stall;
  logic [2:0]  fifo_count;

  wb_req_t exp_q[$];
  wb_req_t exp_head;
  int      compared   = 0;
  int      mismatched = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rd_wren_W   (rd_wren),
    .i_rd_addr_W   (rd_addr),
    .i_result_W    (result),
    .i_mdu_valid   (mdu_valid),
    .i_mdu_rd_addr (mdu_rd_addr),
    .i_mdu_data    (mdu_data),
    .o_mdu_ready   (mdu_ready),
    .o_rf_wren     (rf_wren),
    .o_rf_addr     (rf_addr),
    .o_rf_data     (rf_data),
    .o_stall_W     (stall),
    .o_fifo_count  (fifo_count)
  );

  function automatic wb_req_t mk(input int rd, input logic [31:0] data);
    wb_req_t r;
    r.rd   = 5'(rd);
    r.data = data;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
    rd_wren     = pw;
    rd_addr     = pa;
    result      = pd;
    mdu_valid   = mv;
    mdu_rd_addr = ma;
    mdu_data    = md;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every register-file write is matched in order against the expected queue.
  always @(negedge clk) begin
    if (rf_wren !== 1'b0) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL rf_write: got x%0d=0x%08h expected no write", rf_addr, rf_data);
      end else begin
        exp_head = exp_q.pop_front();
        if ({rf_addr, rf_data} !== exp_head) begin
          mismatched++;
          $display("FAIL rf_write: got x%0d=0x%08h expected x%0d=0x%08h",
                   rf_addr, rf_data, exp_head.rd, exp_head.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int j;
    int n;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_wren", 32'(rf_wren), 32'd0);
    check("reset_ready", 32'(mdu_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Bypass with WB idle
    exp_q.push_back(mk(5, 32'hDEADBEEF));
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("bypass_wren", 32'(rf_wren), 32'd1);
    check("bypass_count", 32'(fifo_count), 32'd0);
    tick();
    idle();
    @(negedge clk);
    check("bypass_count_after", 32'(fifo_count), 32'd0);
    tick();

    // Pipeline wins, MDU result buffered then drained
    exp_q.push_back(mk(3, 32'h11));
    exp_q.push_back(mk(7, 32'h22));
    set_in(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    @(negedge clk);
    check("prio_wren", 32'(rf_wren), 32'd1);
    check("prio_ready", 32'(mdu_ready), 32'd1);
    tick();
    idle();
    @(negedge clk);
    check("prio_count_1", 32'(fifo_count), 32'd1);
    check("prio_drain_wren", 32'(rf_wren), 32'd1);
    tick();
    @(negedge clk);
    check("prio_count_0", 32'(fifo_count), 32'd0);
    tick();

    // Five MDU results against a busy pipeline: back-pressure when full
    begin
      int exp_cnt[11] = '{0, 1, 2, 3, 4, 4, 4, 3, 3, 2, 1};
      for (int k = 0; k < 6; k++) exp_q.push_back(mk(1, 32'(32'h100 + k)));
      for (int m = 0; m < 5; m++) exp_q.push_back(mk(10 + m, 32'(32'hA0 + m)));
      j = 0;
      for (int k = 0; k < 11; k++) begin
        set_in(k < 6, 5'd1, 32'(32'h100 + k), j < 5, 5'(10 + j), 32'(32'hA0 + j));
        @(negedge clk);
        check($sformatf("full_count_c%0d", k), 32'(fifo_count), 32'(exp_cnt[k]));
        check($sformatf("full_ready_c%0d", k), 32'(mdu_ready), 32'((k < 4) || (k > 6)));
        check($sformatf("full_stall_c%0d", k), 32'(stall), 32'd0);
        if (mdu_valid && mdu_ready) j++;
        tick();
      end
      idle();
      @(negedge clk);
      check("full_count_end", 32'(fifo_count), 32'd0);
      check("full_accepts", 32'(j), 32'd5);
      tick();
    end

    // Starvation: one buffered entry loses 8 cycles, then a forced drain
    for (int k = 0; k < 9; k++) exp_q.push_back(mk(2, 32'(32'h200 + k)));
    exp_q.push_back(mk(9, 32'h900));
    exp_q.push_back(mk(2, 32'h209));
    n = 0;
    for (int k = 0; k < 11; k++) begin
      set_in(1'b1, 5'd2, 32'(32'h200 + n), k == 0, 5'd9, 32'h900);
      @(negedge clk);
      check($sformatf("starve_stall_c%0d", k), 32'(stall), 32'(k == 9));
      check($sformatf("starve_count_c%0d", k), 32'(fifo_count), 32'((k >= 1) && (k <= 9)));
      if (!stall) n++;
      tick();
    end
    idle();
    @(negedge clk);
    check("starve_count_end", 32'(fifo_count), 32'd0);
    check("starve_stall_end", 32'(stall), 32'd0);
    tick();

    // x0 destinations are dropped on both sources
    set_in(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    @(negedge clk);
    check("x0_wren", 32'(rf_wren), 32'd0);
    check("x0_ready", 32'(mdu_ready), 32'd1);
    tick();
    idle();
    @(negedge clk);
    check("x0_count", 32'(fifo_count), 32'd0);
    tick();

    // Asynchronous reset with three buffered results and stall active
    for (int k = 0; k < 9; k++) exp_q.push_back(mk(4, 32'(32'h400 + k)));
    for (int k = 0; k < 9; k++) begin
      set_in(1'b1, 5'd4, 32'(32'h400 + k), k < 3, 5'(20 + k), 32'(32'hC0 + k));
      @(negedge clk);
      check($sformatf("rst_fill_count_c%0d", k), 32'(fifo_count), 32'((k < 3) ? k : 3));
      tick();
    end
    set_in(1'b1, 5'd4, 32'h409, 1'b0, 5'd0, 32'd0);
    check("pre_rst_stall", 32'(stall), 32'd1);
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_count", 32'(fifo_count), 32'd0);
    check("async_rst_stall", 32'(stall), 32'd0);
    check("async_rst_wren", 32'(rf_wren), 32'd0);
    @(negedge clk);
    check("in_rst_wren", 32'(rf_wren), 32'd0);
    tick();
    tick();
    idle();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_count_c%0d", k), 32'(fifo_count), 32'd0);
      check($sformatf("post_rst_stall_c%0d", k), 32'(stall), 32'd0);
      tick();
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
